// File: rtl/adder_arbiter.sv
`default_nettype none
// adder_arbiter: round-robin arbiter sequencing two requesters onto one
// registered WIDTH-bit add/subtract datapath (IDLE -> EXEC -> DONE). Rev 1.0
module adder_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             sub0,
   input  logic             sub1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             prio;
   logic             owner;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;
   logic             win;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum_ext;
   logic             ovf_next;

   // Single requester wins outright; a tie goes to the requester named by prio.
   always_comb begin
      win      = (req0 & req1) ? prio : req1;
      bx       = sub_q ? ~b_q : b_q;
      sum_ext  = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_q};
      ovf_next = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         prio   <= 1'b0;
         owner  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sub_q  <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  a_q   <= win ? a1 : a0;
                  b_q   <= win ? b1 : b0;
                  sub_q <= win ? sub1 : sub0;
                  owner <= win;
                  prio  <= ~win;
                  state <= EXEC;
               end
            end
            EXEC: begin
               result <= sum_ext[WIDTH-1:0];
               carry  <= sum_ext[WIDTH];
               ovf    <= ovf_next;
               state  <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign gnt0  = (state == EXEC) && !owner;
   assign gnt1  = (state == EXEC) &&  owner;
   assign done0 = (state == DONE) && !owner;
   assign done1 = (state == DONE) &&  owner;
   assign busy  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// tb_adder_arbiter: directed plus randomized checks of adder_arbiter against
// an arithmetic reference model.
module tb_adder_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        sub0 = 1'b0, sub1 = 1'b0;
   logic        gnt0, gnt1, done0, done1, carry, ovf, busy;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   adder_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .sub0(sub0), .sub1(sub1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .carry(carry), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on the operand values.
   function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] r, output logic c, output logic v);
      longint sa, sb, sr;
      logic [32:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         r  = a - b;
         c  = (a >= b);
         sr = sa - sb;
      end else begin
         u  = {1'b0, a} + {1'b0, b};
         r  = u[31:0];
         c  = u[32];
         sr = sa + sb;
      end
      v = (sr > longint'(32'sh7FFFFFFF)) || (sr < -longint'(32'sh7FFFFFFF) - 64'sd1);
   endfunction

   task automatic start(input int p, input logic [31:0] a, input logic [31:0] b, input logic s);
      if (p == 0) begin req0 = 1'b1; a0 = a; b0 = b; sub0 = s; end
      else        begin req1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
   endtask

   task automatic drop(input int p);
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   // Called at a negedge with the DUT idle and port p requesting (and winning).
   task automatic expect_op(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input bit hold);
      logic [31:0] r;
      logic        c, v;
      logic [1:0]  onehot;
      onehot = (p == 0) ? 2'b01 : 2'b10;
      ref_op(a, b, s, r, c, v);
      @(negedge clk);
      check_val("gnt", {62'd0, gnt1, gnt0}, {62'd0, onehot});
      check_val("busy_exec", busy, 1);
      check_val("done_in_exec", {62'd0, done1, done0}, 0);
      if (!hold) begin
         drop(p);
         if (p == 0) begin a0 = ~a0; b0 = b0 + 32'd17; sub0 = ~sub0; end
         else        begin a1 = ~a1; b1 = b1 + 32'd17; sub1 = ~sub1; end
      end
      @(negedge clk);
      check_val("done", {62'd0, done1, done0}, {62'd0, onehot});
      check_val("gnt_in_done", {62'd0, gnt1, gnt0}, 0);
      check_val("result", result, r);
      check_val("carry", carry, c);
      check_val("ovf", ovf, v);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check_val("busy_idle", busy, 0);
      check_val("gnt_done_idle", {60'd0, gnt1, gnt0, done1, done0}, 0);
   endtask

   task automatic one_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic s);
      start(p, a, b, s);
      expect_op(p, a, b, s, 1'b1);
      drop(p);
      idle_cycle();
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          rp;

      // Reset values
      @(negedge clk);
      check_val("rst_outputs", {58'd0, gnt1, gnt0, done1, done0, busy, carry},  0);
      check_val("rst_result", {31'd0, ovf, result}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Round-robin with both requests held from reset: order 0,1,0,1
      a0 = 32'd100; b0 = 32'd11; sub0 = 1'b0;
      a1 = 32'd50;  b1 = 32'd70; sub1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) expect_op(0, 32'd100, 32'd11, 1'b0, 1'b1);
         else            expect_op(1, 32'd50, 32'd70, 1'b1, 1'b1);
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         @(negedge clk);
         check_val("rr_idle_busy", busy, 0);
      end
      idle_cycle();

      // Directed arithmetic cases
      one_op(0, 32'd5, 32'd3, 1'b0);
      one_op(1, 32'd3, 32'd5, 1'b1);
      check_val("sub_borrow_const", {31'd0, carry, result}, {31'd0, 1'b0, 32'hFFFFFFFE});
      one_op(1, 32'd5, 32'd3, 1'b1);
      check_val("sub_noborrow_const", {31'd0, carry, result}, {31'd0, 1'b1, 32'd2});
      one_op(0, 32'h7FFFFFFF, 32'd1, 1'b0);
      check_val("ovf_add_const", {31'd0, ovf, result}, {31'd0, 1'b1, 32'h80000000});
      one_op(1, 32'h80000000, 32'd1, 1'b1);
      check_val("ovf_sub_const", {30'd0, ovf, carry, result}, {30'd0, 2'b11, 32'h7FFFFFFF});
      one_op(0, 32'hFFFFFFFF, 32'd1, 1'b0);
      check_val("wrap_add_const", {30'd0, ovf, carry, result}, {30'd0, 2'b01, 32'd0});

      // Reset in EXEC: no done, outputs cleared, prio cleared
      start(0, 32'd7, 32'd9, 1'b0);
      @(negedge clk);
      check_val("mid_gnt0", gnt0, 1);
      reset = 1'b1;
      drop(0);
      #1;
      check_val("mid_async_busy", {62'd0, busy, gnt0}, 0);
      @(negedge clk);
      check_val("mid_no_done", {62'd0, done1, done0}, 0);
      check_val("mid_result", {31'd0, ovf, result}, 0);
      check_val("mid_carry_busy", {62'd0, carry, busy}, 0);
      reset = 1'b0;
      @(negedge clk);
      start(0, 32'd7, 32'd9, 1'b0);
      start(1, 32'd1, 32'd2, 1'b0);
      expect_op(0, 32'd7, 32'd9, 1'b0, 1'b1);
      drop(0);
      idle_cycle();
      expect_op(1, 32'd1, 32'd2, 1'b0, 1'b1);
      drop(1);
      idle_cycle();

      // Request drop and operand change during EXEC
      start(0, 32'd1000, 32'd234, 1'b1);
      expect_op(0, 32'd1000, 32'd234, 1'b1, 1'b0);
      idle_cycle();
      idle_cycle();

      // Randomized single-requester operations
      for (int n = 0; n < 24; n++) begin
         rp = $urandom_range(0, 1);
         ra = $urandom();
         rb = (n % 4 == 0) ? 32'd1 : $urandom();
         rs = 1'($urandom_range(0, 1));
         start(rp, ra, rb, rs);
         expect_op(rp, ra, rb, rs, 1'($urandom_range(0, 1)));
         drop(rp);
         idle_cycle();
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
